// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB3 register-bank completer.
// Optional byte-strobe support is compiled in with APB_SLV_PSTRB_EN.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [31:0] ID_VALUE     = 32'hA2B0_0001;
    localparam int          OFF_ID       = 'h0;
    localparam int          OFF_CNT      = 'h4;
    localparam int          OFF_SCRATCH0 = 'h8;

    // Byte-offset field width: word index bits plus the two byte-lane bits.
    function automatic int off_width(input int num_regs);
        return $clog2(num_regs) + 2;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                m[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_slv_regbank.sv
// Register storage, offset decode and access-error check for apb_slave_regs.
// With APB_SLV_PSTRB_EN defined, a read carrying nonzero strobes is an error.
module apb_slv_regbank
    import apb_slv_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int OFF_W    = off_width(NUM_REGS)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [OFF_W-1:0] i_off,
    input  logic             i_write,
    input  logic [3:0]       i_strb,
    input  logic [31:0]      i_wdata,
    input  logic             i_wr_en,
    input  logic [15:0]      i_xfer_cnt,
    output logic [31:0]      o_rdata,
    output logic             o_err
);

    localparam int IDX_W = OFF_W - 2;

    logic [IDX_W-1:0] w_idx;
    logic             w_out_of_range;
    logic             w_misaligned;
    logic             w_ro_write;
    logic             w_strb_err;

    logic [31:0] r_scratch [2:NUM_REGS-1];

    assign w_idx          = i_off[OFF_W-1:2];
    assign w_out_of_range = ({1'b0, i_off} >= (OFF_W+1)'(NUM_REGS * 4));
    assign w_misaligned   = (i_off[1:0] != 2'b00);
    assign w_ro_write     = i_write && ((i_off == OFF_W'(OFF_ID)) || (i_off == OFF_W'(OFF_CNT)));

`ifdef APB_SLV_PSTRB_EN
    assign w_strb_err = !i_write && (i_strb != 4'b0000);
`else
    assign w_strb_err = 1'b0;
`endif

    assign o_err = w_out_of_range || w_misaligned || w_ro_write || w_strb_err;

    generate
        for (genvar gi = OFF_SCRATCH0 / 4; gi < NUM_REGS; gi++) begin : g_scratch
            always_ff @(posedge clk) begin
                if (srst) begin
                    r_scratch[gi] <= '0;
                end else if (i_wr_en && (w_idx == IDX_W'(gi))) begin
                    r_scratch[gi] <= strb_merge(r_scratch[gi], i_wdata, i_strb);
                end
            end
        end
    endgenerate

    always_comb begin
        o_rdata = '0;
        if (w_idx == IDX_W'(OFF_ID / 4)) begin
            o_rdata = ID_VALUE;
        end else if (w_idx == IDX_W'(OFF_CNT / 4)) begin
            o_rdata = {16'h0000, i_xfer_cnt};
        end else begin
            for (int i = OFF_SCRATCH0 / 4; i < NUM_REGS; i++) begin
                if (w_idx == IDX_W'(i)) begin
                    o_rdata = r_scratch[i];
                end
            end
        end
    end

endmodule

// File: rtl/apb_slave_regs.sv
// APB3 completer with programmable wait states, serving ID, XFER_CNT and scratch registers.
// Define APB_SLV_PSTRB_EN to add the APB4 pstrb input and byte-masked scratch writes.
module apb_slave_regs
    import apb_slv_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    input  logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int OFF_W = off_width(NUM_REGS);

    state_t             r_state;
    logic [3:0]         r_wait_cnt;
    logic [OFF_W-1:0]   r_addr;
    logic               r_write;
    logic [DATA_W-1:0]  r_wdata;
    logic [3:0]         r_strb;
    logic [15:0]        r_xfer_cnt;
    logic               r_pready;
    logic               r_pslverr;
    logic [DATA_W-1:0]  r_prdata;

    logic [OFF_W-1:0]   w_dec_off;
    logic               w_dec_write;
    logic [3:0]         w_dec_strb;
    logic [3:0]         w_in_strb;
    logic [31:0]        w_rdata;
    logic               w_err;
    logic               w_wr_en;
    logic [DATA_W-1:0]  w_resp_data;
    logic               w_unused_paddr;

    assign w_unused_paddr = ^paddr[ADDR_W-1:OFF_W];

`ifdef APB_SLV_PSTRB_EN
    assign w_in_strb = pstrb;
`else
    assign w_in_strb = 4'hF;
`endif

    // In IDLE the decode looks at the live setup-phase bus so a zero-wait
    // response can be registered on the setup edge; afterwards it uses the capture.
    assign w_dec_off   = (r_state == IDLE) ? paddr[OFF_W-1:0] : r_addr;
    assign w_dec_write = (r_state == IDLE) ? pwrite : r_write;
    assign w_dec_strb  = (r_state == IDLE) ? w_in_strb : r_strb;

    assign w_resp_data = (w_dec_write || w_err) ? '0 : w_rdata;
    assign w_wr_en     = (r_state == READY) && psel && r_write && !r_pslverr;

    apb_slv_regbank #(
        .NUM_REGS (NUM_REGS),
        .OFF_W    (OFF_W)
    ) u_regbank (
        .clk        (hclk),
        .srst       (hreset),
        .i_off      (w_dec_off),
        .i_write    (w_dec_write),
        .i_strb     (w_dec_strb),
        .i_wdata    (r_wdata),
        .i_wr_en    (w_wr_en),
        .i_xfer_cnt (r_xfer_cnt),
        .o_rdata    (w_rdata),
        .o_err      (w_err)
    );

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_xfer_cnt <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            case (r_state)
                IDLE: begin
                    if (psel && !penable) begin
                        r_addr     <= paddr[OFF_W-1:0];
                        r_write    <= pwrite;
                        r_wdata    <= pwdata;
                        r_strb     <= w_in_strb;
                        r_wait_cnt <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            r_state   <= READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= w_resp_data;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        r_state <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                        if (r_wait_cnt == 4'd1) begin
                            r_state   <= READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= w_resp_data;
                        end
                    end
                end
                READY: begin
                    r_state <= IDLE;
                    if (psel) begin
                        r_xfer_cnt <= r_xfer_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
APB3 completer that sits directly downstream of the AHB-to-APB bridge. It consumes the bridge's APB transfers and serves them from a small register bank. It inserts a programmable number of wait states through pready and flags illegal accesses through pslverr. It is the default target that benches attach to the bridge's APB port, so bridge read and write transactions complete against real storage.

Parameters:
- ADDR_W, 32, paddr width.
- DATA_W, 32, pwdata/prdata width; fixed at 32 for this block.
- NUM_REGS, 8, number of word registers; minimum 3.
- WAIT_CYCLES, 1, wait states inserted in every access phase; range 0..15.

Ports:
- hclk  input  1  APB/AHB clock, rising edge.
- hreset  input  1  synchronous active-high reset.
- psel  input  1  slave select.
- penable  input  1  access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  byte address; only the low offset bits are decoded.
- pwdata  input  DATA_W  write data.
- prdata  output  DATA_W  read data; valid only while pready=1 on a read.
- pready  output  1  transfer completes this cycle.
- pslverr  output  1  error response; valid only while pready=1.

Behaviour:
- Clock and reset:
  - Single clock domain, hclk.
  - hreset is sampled on the hclk rising edge (synchronous, active-high).
  - While hreset=1: FSM goes to IDLE; pready, pslverr and prdata are 0; scratch registers and XFER_CNT are 0.
  - Reset asserted mid-transfer aborts the transfer; no write commits.
- Register map (word offsets):
  - 0x0 ID: read-only, 32'hA2B0_0001.
  - 0x4 XFER_CNT: read-only, 16-bit, zero-extended; increments once per completed transfer (OK or error) and wraps 0xFFFF -> 0.
  - 0x8 up to (NUM_REGS-1)*4: read/write scratch registers.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - On psel=1 and penable=0 (setup phase), capture paddr, pwrite and pwdata, and load wait_cnt <= WAIT_CYCLES.
  - Next state is READY if WAIT_CYCLES==0, else WAIT.
  - penable=1 seen in IDLE (no preceding setup) is ignored; pready stays 0.
- WAIT:
  - wait_cnt decrements each cycle.
  - When wait_cnt==1, next state is READY.
- Latency: pready is registered and goes high exactly WAIT_CYCLES+1 cycles after the setup cycle. With WAIT_CYCLES=0 it is high in the first access cycle.
- READY:
  - pready=1 for exactly one cycle; next state is IDLE.
  - A back-to-back setup in the following cycle is accepted normally.
- Write commit: on the rising edge that ends the READY cycle, if no error. Read data is driven during READY from the value current at that time.
- Error condition: any of
  - captured address offset >= NUM_REGS*4,
  - paddr[1:0] != 0,
  - write to 0x0 or 0x4.
- On error:
  - pslverr=1 together with pready.
  - Write is suppressed.
  - prdata=0.
  - XFER_CNT still increments.
- prdata is 0 whenever pready=0 or the transfer is a write.
- Protocol violation: psel falling to 0 in WAIT or READY sends the FSM to IDLE next cycle. That transfer has no commit, no count and no pready.
- Address decode uses only paddr[$clog2(NUM_REGS)+1:0]; upper bits are ignored (aliasing is intended).

Optional Feature:
- Macro: APB_SLV_PSTRB_EN.
- Defined:
  - Adds input port pstrb[DATA_W/8-1:0] (APB4 byte strobes), captured in the setup phase.
  - Scratch writes update only the bytes whose strobe bit is set.
  - pstrb==0 on a write is a legal no-op that still counts.
  - A nonzero pstrb on a read sets pslverr.
- Undefined: no pstrb port; every write updates all 4 bytes.

Decomposition:
- Package apb_slv_pkg holds:
  - the state enum (IDLE, WAIT, READY),
  - ID_VALUE,
  - offset constants OFF_ID=0x0, OFF_CNT=0x4, OFF_SCRATCH0=0x8.
- Sub-module apb_slv_regbank holds storage, address decode and the error check. Inputs: captured address, write data, write enable, strobes. Outputs: read data, err.
- Top level holds the FSM, wait counter and XFER_CNT.

Test Plan:
- Reset/ID: assert hreset 3 cycles, then read 0x0 -> prdata=32'hA2B0_0001, pslverr=0, pready high exactly 2 cycles after setup (WAIT_CYCLES=1).
- Write then read: write 32'hDEAD_BEEF to 0x8, read 0x8 -> 32'hDEAD_BEEF; read 0x4 -> 32'h0000_0002.
- Errors:
  - Write to 0x0 -> pslverr=1, ID unchanged.
  - Read 0x20 with NUM_REGS=8 -> pslverr=1, prdata=0.
  - Read 0xA (misaligned) -> pslverr=1.
- Wait states: WAIT_CYCLES=0 -> pready in first access cycle. WAIT_CYCLES=3 -> pready in fourth access cycle. Back-to-back transfers both complete.
- Abort/reset: drop psel during WAIT on a write of 32'h1234_5678 to 0xC -> 0xC still 0, XFER_CNT unchanged. Assert hreset mid-wait -> pready=0 next cycle, all registers 0.
- Strobes (APB_SLV_PSTRB_EN): 0x8 holds 32'hFFFF_FFFF; write 32'h0000_0000 with pstrb=4'b0101 -> read 32'hFF00_FF00.
